// File: rtl/pe_rx_checker.sv
// pe_rx_checker: receive-end leaf PE for the BFT test network.
// Sinks packets, checks sequence numbers, buffers payloads for the host
// and returns one ack per accepted packet, holding it while resend is high.
// Optional payload check: define PE_PAYLOAD_CHK_EN.
module pe_rx_checker #(
    parameter int num_leaves = 256,
    parameter int p_sz       = 32,
    parameter int HOST_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [p_sz-1:0] interface_pe,
    input  logic            resend,
    output logic [p_sz-1:0] pe_interface,
    input  logic            rd_en,
    output logic            rd_valid,
    output logic [14:0]     rd_data,
    output logic [15:0]     rx_count,
    output logic [15:0]     err_count,
    output logic [15:0]     ovf_count,
    output logic [15:0]     ack_drop_count
);

    localparam int L      = $clog2(num_leaves);
    localparam int SEQ_W  = 8;
    localparam int PAY_W  = 15;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [L-1:0] HOST_FIELD = HOST_ADDR[L-1:0];

    typedef enum logic {UNSYNC, SYNC} chk_state_t;
    typedef enum logic [1:0] {IDLE, SENT, HOLD} ack_state_t;

    // Packet field extraction
    logic             pkt_valid;
    logic [SEQ_W-1:0] pkt_seq;
    logic [PAY_W-1:0] pkt_pay;
    logic             unused_addr;

    assign pkt_valid   = interface_pe[p_sz-1];
    assign pkt_seq     = interface_pe[PAY_W +: SEQ_W];
    assign pkt_pay     = interface_pe[PAY_W-1:0];
    // The destination address is already resolved by the network.
    assign unused_addr = ^interface_pe[p_sz-2 -: L];

    // ------------------------------------------------------------------
    // Sequence checker
    // ------------------------------------------------------------------
    chk_state_t       chk_state_reg, chk_state_next;
    logic [SEQ_W-1:0] exp_seq_reg, exp_seq_next;
    logic             seq_err;
    logic             pay_err;
    logic             mismatch;

    // Checker state and expected sequence register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_state_reg <= UNSYNC;
            exp_seq_reg   <= '0;
        end else begin
            chk_state_reg <= chk_state_next;
            exp_seq_reg   <= exp_seq_next;
        end
    end

    // Any packet resyncs the expectation; only SYNC reports errors
    always_comb begin
        chk_state_next = chk_state_reg;
        exp_seq_next   = exp_seq_reg;
        seq_err        = 1'b0;
        if (pkt_valid) begin
            exp_seq_next   = pkt_seq + SEQ_W'(1);
            chk_state_next = SYNC;
            if (chk_state_reg == SYNC) begin
                seq_err = (pkt_seq != exp_seq_reg);
            end
        end
    end

`ifdef PE_PAYLOAD_CHK_EN
    logic [PAY_W-1:0] exp_pay_reg, exp_pay_next;

    // Expected payload register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_pay_reg <= '0;
        end else begin
            exp_pay_reg <= exp_pay_next;
        end
    end

    // Payload expectation tracks every packet, including the sync packet
    always_comb begin
        exp_pay_next = exp_pay_reg;
        pay_err      = 1'b0;
        if (pkt_valid) begin
            exp_pay_next = pkt_pay + PAY_W'(1);
            pay_err      = (chk_state_reg == SYNC) && (pkt_pay != exp_pay_reg);
        end
    end
`else
    assign pay_err = 1'b0;
`endif

    // Sequence and payload errors on one packet count once
    assign mismatch = seq_err | pay_err;

    // ------------------------------------------------------------------
    // Payload FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [PAY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] fifo_cnt_reg;
    logic             fifo_full;
    logic             fifo_pop;
    logic             fifo_wr;

    assign rd_valid  = (fifo_cnt_reg != '0);
    assign fifo_full = (fifo_cnt_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_pop  = rd_en && rd_valid;
    // A pop in the same cycle frees a slot for the incoming payload
    assign fifo_wr   = pkt_valid && (!fifo_full || fifo_pop);
    assign rd_data   = rd_valid ? mem[rd_ptr_reg] : '0;

    // Payload storage
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr_reg] <= pkt_pay;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({fifo_wr, fifo_pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ack return path
    // ------------------------------------------------------------------
    ack_state_t      ack_state_reg, ack_state_next;
    logic [p_sz-1:0] ack_reg, ack_next;
    logic [p_sz-1:0] new_ack;
    logic            ack_drop_inc;

    assign new_ack      = {1'b1, HOST_FIELD, pkt_seq, {(PAY_W-1){1'b0}}, mismatch};
    assign pe_interface = ack_reg;

    // Ack state and presented ack packet
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_state_reg <= IDLE;
            ack_reg       <= '0;
        end else begin
            ack_state_reg <= ack_state_next;
            ack_reg       <= ack_next;
        end
    end

    // Resend freezes the current ack; a packet arriving meanwhile loses its ack
    always_comb begin
        ack_state_next = ack_state_reg;
        ack_next       = ack_reg;
        ack_drop_inc   = 1'b0;
        case (ack_state_reg)
            IDLE: begin
                if (pkt_valid) begin
                    ack_state_next = SENT;
                    ack_next       = new_ack;
                end
            end
            SENT, HOLD: begin
                if (resend) begin
                    ack_state_next = HOLD;
                    ack_drop_inc   = pkt_valid;
                end else if (pkt_valid) begin
                    ack_state_next = SENT;
                    ack_next       = new_ack;
                end else begin
                    ack_state_next = IDLE;
                    ack_next       = '0;
                end
            end
            default: begin
                ack_state_next = IDLE;
                ack_next       = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating statistics counters: rx, err, ovf, ack_drop
    // ------------------------------------------------------------------
    logic [3:0]       cnt_inc;
    logic [3:0][15:0] cnt_bus;

    assign cnt_inc = {ack_drop_inc,
                      pkt_valid && fifo_full && !fifo_pop,
                      pkt_valid && mismatch,
                      pkt_valid};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            logic [15:0] count_reg;

            // Count events, sticking at all-ones
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg <= '0;
                end else if (cnt_inc[gi] && (count_reg != 16'hFFFF)) begin
                    count_reg <= count_reg + 16'd1;
                end
            end

            assign cnt_bus[gi] = count_reg;
        end
    endgenerate

    assign rx_count       = cnt_bus[0];
    assign err_count      = cnt_bus[1];
    assign ovf_count      = cnt_bus[2];
    assign ack_drop_count = cnt_bus[3];

endmodule

// File: tb/tb_pe_rx_checker.sv
// Self-checking bench for pe_rx_checker with a payload scoreboard.
// Build with PE_PAYLOAD_CHK_EN defined to exercise the payload check.
module tb_pe_rx_checker;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] interface_pe;
    logic        resend;
    logic [31:0] pe_interface;
    logic        rd_en;
    logic        rd_valid;
    logic [14:0] rd_data;
    logic [15:0] rx_count, err_count, ovf_count, ack_drop_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_sync;
    logic [7:0]  m_exp_seq;
    logic [14:0] m_exp_pay;
    int          m_rx, m_err, m_ovf, m_drop;
    int          m_ack_st;
    logic [31:0] m_ack;
    logic [14:0] sb[$];

    pe_rx_checker #(
        .num_leaves(256),
        .p_sz      (32),
        .HOST_ADDR (0),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .interface_pe  (interface_pe),
        .resend        (resend),
        .pe_interface  (pe_interface),
        .rd_en         (rd_en),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rx_count      (rx_count),
        .err_count     (err_count),
        .ovf_count     (ovf_count),
        .ack_drop_count(ack_drop_count)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_sync    = 1'b0;
        m_exp_seq = '0;
        m_exp_pay = '0;
        m_rx = 0; m_err = 0; m_ovf = 0; m_drop = 0;
        m_ack_st = 0;
        m_ack    = '0;
        sb.delete();
    endtask

    // Called at posedge+1; drives one cycle, updates the model, returns at next posedge+1
    task automatic cycle(input logic v, input logic [7:0] seq, input logic [14:0] pay,
                         input logic rd, input logic rs,
                         output logic [14:0] pre_data, output logic [14:0] exp_pop,
                         output logic popped);
        logic        mism;
        logic [31:0] new_ack;
        interface_pe = v ? {1'b1, 8'h5A, seq, pay} : 32'h0;
        rd_en        = rd;
        resend       = rs;
        pre_data     = rd_data;
        mism = 1'b0;
        if (v && m_sync && (seq != m_exp_seq)) mism = 1'b1;
`ifdef PE_PAYLOAD_CHK_EN
        if (v && m_sync && (pay != m_exp_pay)) mism = 1'b1;
`endif
        popped  = 1'b0;
        exp_pop = '0;
        if (rd && (sb.size() > 0)) begin
            popped  = 1'b1;
            exp_pop = sb.pop_front();
        end
        if (v) begin
            m_rx++;
            if (mism) m_err++;
            if (sb.size() < DEPTH) sb.push_back(pay);
            else m_ovf++;
            m_sync    = 1'b1;
            m_exp_seq = seq + 8'd1;
            m_exp_pay = pay + 15'd1;
        end
        new_ack = {1'b1, 8'h00, seq, 14'b0, mism};
        if (m_ack_st == 0) begin
            if (v) begin m_ack = new_ack; m_ack_st = 1; end
        end else if (rs) begin
            m_ack_st = 2;
            if (v) m_drop++;
        end else if (v) begin
            m_ack = new_ack; m_ack_st = 1;
        end else begin
            m_ack = '0; m_ack_st = 0;
        end
        @(posedge clk);
        #1;
        interface_pe = '0;
        rd_en        = 1'b0;
        resend       = 1'b0;
        $display("txn v=%0d seq=%0d pay=%h rd=%0d rs=%0d -> ack=%h rd_valid=%0d rx=%0d err=%0d",
                 v, seq, pay, rd, rs, pe_interface, rd_valid, rx_count, err_count);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        logic [14:0] pre, exp;
        logic        pp;
        cycle(1'b1, 8'd40, 15'h100, 1'b0, 1'b0, pre, exp, pp);
        cycle(1'b1, 8'd41, 15'h101, 1'b0, 1'b1, pre, exp, pp);
        if (ack_drop_count !== 16'd1) begin miscompares++;
            $display("FAIL pre_reset_drop got %0d want 1", ack_drop_count); end
        vectors++;
        // Mid-retry, between clock edges
        reset_n = 1'b0;
        #1;
        if ({pe_interface, rd_valid, rd_data} !== 48'h0) begin miscompares++;
            $display("FAIL reset_outputs got ack=%h v=%b d=%h want 0", pe_interface, rd_valid, rd_data); end
        vectors++;
        if ({rx_count, err_count, ovf_count, ack_drop_count} !== 64'h0) begin miscompares++;
            $display("FAIL reset_counters got %h %h %h %h want 0", rx_count, err_count, ovf_count, ack_drop_count); end
        vectors++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
        cycle(1'b1, 8'd200, 15'h300, 1'b0, 1'b0, pre, exp, pp);
        cycle(1'b1, 8'd201, 15'h301, 1'b0, 1'b0, pre, exp, pp);
        if (err_count !== 16'd0) begin miscompares++;
            $display("FAIL post_reset_err got %0d want 0", err_count); end
        vectors++;
        if (rx_count !== 16'd2) begin miscompares++;
            $display("FAIL post_reset_rx got %0d want 2", rx_count); end
        vectors++;
    endtask

    task automatic test_in_order();
        logic [14:0] pre, exp;
        logic        pp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'(5 + i), 15'(16 + i), 1'b0, 1'b0, pre, exp, pp);
            if (rd_valid !== 1'b1) begin miscompares++;
                $display("FAIL inorder_rd_valid got %b want 1", rd_valid); end
            vectors++;
        end
        if (rx_count !== 16'd3 || err_count !== 16'd0) begin miscompares++;
            $display("FAIL inorder_counts got rx=%0d err=%0d want rx=3 err=0", rx_count, err_count); end
        vectors++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'd0, 15'd0, 1'b1, 1'b0, pre, exp, pp);
            if (!pp || pre !== exp) begin miscompares++;
                $display("FAIL inorder_pop got %h want %h", pre, exp); end
            vectors++;
        end
        if (rd_valid !== 1'b0) begin miscompares++;
            $display("FAIL inorder_empty got %b want 0", rd_valid); end
        vectors++;
    endtask

    task automatic test_seq_error();
        logic [14:0] pre, exp;
        logic        pp;
        do_reset();
        cycle(1'b1, 8'd5, 15'h20, 1'b0, 1'b0, pre, exp, pp);
        cycle(1'b1, 8'd7, 15'h21, 1'b0, 1'b0, pre, exp, pp);
        if (err_count !== 16'd1) begin miscompares++;
            $display("FAIL seqerr_count got %0d want 1", err_count); end
        vectors++;
        if (pe_interface !== {1'b1, 8'h00, 8'd7, 14'b0, 1'b1}) begin miscompares++;
            $display("FAIL seqerr_ack got %h want %h", pe_interface, {1'b1, 8'h00, 8'd7, 14'b0, 1'b1}); end
        vectors++;
        cycle(1'b1, 8'd8, 15'h22, 1'b0, 1'b0, pre, exp, pp);
        if (err_count !== 16'd1) begin miscompares++;
            $display("FAIL seqerr_resync got %0d want 1", err_count); end
        vectors++;
        if (pe_interface !== {1'b1, 8'h00, 8'd8, 14'b0, 1'b0}) begin miscompares++;
            $display("FAIL seqerr_ack_ok got %h want %h", pe_interface, {1'b1, 8'h00, 8'd8, 14'b0, 1'b0}); end
        vectors++;
    endtask

    task automatic test_overflow();
        logic [14:0] pre, exp;
        logic        pp;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(1 + i), 15'(48 + i), 1'b0, 1'b0, pre, exp, pp);
        if (ovf_count !== 16'd1 || rd_valid !== 1'b1) begin miscompares++;
            $display("FAIL ovf_full got ovf=%0d v=%b want ovf=1 v=1", ovf_count, rd_valid); end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'd0, 15'd0, 1'b1, 1'b0, pre, exp, pp);
            if (!pp || pre !== exp) begin miscompares++;
                $display("FAIL ovf_pop got %h want %h", pre, exp); end
            vectors++;
        end
        if (rd_valid !== 1'b0) begin miscompares++;
            $display("FAIL ovf_drained got %b want 0", rd_valid); end
        vectors++;
        // Fifth packet arrives together with a pop
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(1 + i), 15'(48 + i), (i == 4) ? 1'b1 : 1'b0, 1'b0, pre, exp, pp);
            if (pp && pre !== exp) begin miscompares++;
                $display("FAIL ovf_pop_wr got %h want %h", pre, exp); end
            if (pp) vectors++;
        end
        if (ovf_count !== 16'd0) begin miscompares++;
            $display("FAIL ovf_popwrite got %0d want 0", ovf_count); end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'd0, 15'd0, 1'b1, 1'b0, pre, exp, pp);
            if (!pp || pre !== exp) begin miscompares++;
                $display("FAIL ovf_pop2 got %h want %h", pre, exp); end
            vectors++;
        end
    endtask

    task automatic test_resend();
        logic [14:0] pre, exp;
        logic [31:0] want;
        logic        pp;
        do_reset();
        want = {1'b1, 8'h00, 8'd10, 14'b0, 1'b0};
        cycle(1'b1, 8'd10, 15'h40, 1'b0, 1'b0, pre, exp, pp);
        for (int i = 0; i < 3; i++) begin
            if (pe_interface !== want) begin miscompares++;
                $display("FAIL resend_hold%0d got %h want %h", i, pe_interface, want); end
            vectors++;
            cycle(1'b0, 8'd0, 15'd0, 1'b0, (i < 2) ? 1'b1 : 1'b0, pre, exp, pp);
        end
        if (pe_interface !== 32'h0) begin miscompares++;
            $display("FAIL resend_clear got %h want 0", pe_interface); end
        vectors++;
        want = {1'b1, 8'h00, 8'd11, 14'b0, 1'b0};
        cycle(1'b1, 8'd11, 15'h41, 1'b0, 1'b0, pre, exp, pp);
        cycle(1'b1, 8'd12, 15'h42, 1'b0, 1'b1, pre, exp, pp);
        if (pe_interface !== want || ack_drop_count !== 16'd1) begin miscompares++;
            $display("FAIL resend_drop got ack=%h drop=%0d want ack=%h drop=1", pe_interface, ack_drop_count, want); end
        vectors++;
        cycle(1'b0, 8'd0, 15'd0, 1'b0, 1'b0, pre, exp, pp);
        if (pe_interface !== 32'h0 || rx_count !== 16'd3 || err_count !== 16'd0) begin miscompares++;
            $display("FAIL resend_after got ack=%h rx=%0d err=%0d want 0/3/0", pe_interface, rx_count, err_count); end
        vectors++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'd0, 15'd0, 1'b1, 1'b0, pre, exp, pp);
            if (!pp || pre !== exp) begin miscompares++;
                $display("FAIL resend_pop got %h want %h", pre, exp); end
            vectors++;
        end
    endtask

    task automatic test_wrap();
        logic [14:0] pre, exp;
        logic        pp;
        logic [15:0] want_err;
        do_reset();
        cycle(1'b1, 8'd254, 15'h7FFE, 1'b0, 1'b0, pre, exp, pp);
        cycle(1'b1, 8'd255, 15'h7FFF, 1'b0, 1'b0, pre, exp, pp);
        cycle(1'b1, 8'd0,   15'h0000, 1'b0, 1'b0, pre, exp, pp);
        if (err_count !== 16'd0) begin miscompares++;
            $display("FAIL wrap_err got %0d want 0", err_count); end
        vectors++;
        do_reset();
        cycle(1'b1, 8'd1, 15'h5, 1'b0, 1'b0, pre, exp, pp);
        cycle(1'b1, 8'd2, 15'h9, 1'b0, 1'b0, pre, exp, pp);
`ifdef PE_PAYLOAD_CHK_EN
        want_err = 16'd1;
`else
        want_err = 16'd0;
`endif
        if (err_count !== want_err) begin miscompares++;
            $display("FAIL payload_err got %0d want %0d", err_count, want_err); end
        vectors++;
        if (pe_interface !== {1'b1, 8'h00, 8'd2, 14'b0, want_err[0]}) begin miscompares++;
            $display("FAIL payload_ack got %h want %h", pe_interface, {1'b1, 8'h00, 8'd2, 14'b0, want_err[0]}); end
        vectors++;
    endtask

    task automatic test_back_to_back();
        logic [14:0] pre, exp;
        logic        pp;
        logic        v, rd, rs;
        logic [7:0]  seq;
        logic [14:0] pay;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            v   = (($urandom % 10) < 7);
            rd  = (($urandom % 10) < 4);
            rs  = (($urandom % 10) < 3);
            seq = (($urandom % 8) == 0) ? 8'($urandom) : m_exp_seq;
            pay = (($urandom % 8) == 0) ? 15'($urandom) : m_exp_pay;
            cycle(v, seq, pay, rd, rs, pre, exp, pp);
            if (pp && pre !== exp) begin miscompares++;
                $display("FAIL b2b_pop got %h want %h", pre, exp); end
            if (pp) vectors++;
            if (pe_interface !== m_ack) begin miscompares++;
                $display("FAIL b2b_ack got %h want %h", pe_interface, m_ack); end
            vectors++;
            if (rd_valid !== (sb.size() != 0)) begin miscompares++;
                $display("FAIL b2b_rd_valid got %b want %b", rd_valid, (sb.size() != 0)); end
            vectors++;
        end
        if (rx_count !== 16'(m_rx) || err_count !== 16'(m_err) ||
            ovf_count !== 16'(m_ovf) || ack_drop_count !== 16'(m_drop)) begin miscompares++;
            $display("FAIL b2b_counters got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     rx_count, err_count, ovf_count, ack_drop_count, m_rx, m_err, m_ovf, m_drop); end
        vectors++;
    endtask

    initial begin
        reset_n      = 1'b0;
        interface_pe = '0;
        resend       = 1'b0;
        rd_en        = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_in_order();
        test_seq_error();
        test_overflow();
        test_resend();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
